// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package : p_instruction / p_decode
// Brief   : Instruction enumerations plus decode-stage header layout and
//           field positions of the fixed 32-bit encoding.
// Revision: 1.0 - initial release
// ============================================================================
package p_instruction;

    typedef enum logic [2:0] {
        KIND_RRR     = 3'd0,
        KIND_MEMORY  = 3'd1,
        KIND_MODEL   = 3'd2,
        KIND_RRI     = 3'd3,
        KIND_CUSTOM  = 3'd4,
        KIND_RSVD5   = 3'd5,
        KIND_RSVD6   = 3'd6,
        KIND_INVALID = 3'd7
    } e_kind;

    typedef enum logic [2:0] {
        COND_AL, COND_EQ, COND_NE, COND_LT, COND_GE, COND_LTU, COND_GEU, COND_NV
    } e_cond;

    typedef enum logic [4:0] {
        BINOP_ADD, BINOP_SUB, BINOP_AND, BINOP_OR,  BINOP_XOR,  BINOP_SHL,
        BINOP_SHR, BINOP_SAR, BINOP_MUL, BINOP_MULH, BINOP_DIV, BINOP_DIVU,
        BINOP_REM, BINOP_REMU, BINOP_MIN, BINOP_MAX, BINOP_CMP
    } e_bin_op;

    typedef enum logic [4:0] {
        MEM_LD_B,  MEM_LD_H,  MEM_LD_W,  MEM_LD_BU,  MEM_LD_HU,  MEM_ST_W,
        MEM_LDI_B, MEM_LDI_H, MEM_LDI_W, MEM_LDI_BU, MEM_LDI_HU, MEM_STI_W
    } e_mem_op;

endpackage

package p_decode;
    import p_instruction::*;

    typedef union packed {
        e_bin_op    bin;
        e_mem_op    mem;
        logic [4:0] raw;
    } u_bin_op;

    // rsvd pads the header to the 38-bit issue bus and is always zero
    typedef struct packed {
        e_kind      kind;
        e_cond      cond;
        u_bin_op    op;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rq;
        logic [1:0] shift_type;
        logic [4:0] shift_amt;
        logic [4:0] rsvd;
    } s_dec_hdr;

    localparam int unsigned c_HDR_W        = $bits(s_dec_hdr);
    localparam int unsigned c_KIND_LSB     = 29;
    localparam int unsigned c_COND_LSB     = 26;
    localparam int unsigned c_OP_LSB       = 21;
    localparam int unsigned c_RD_LSB       = 16;
    localparam int unsigned c_RS_LSB       = 11;
    localparam int unsigned c_RQ_LSB       = 6;
    localparam int unsigned c_SHT_LSB      = 4;
    localparam int unsigned c_SHA_LSB      = 0;
    localparam int unsigned c_EXT_BIT      = 10;
    localparam int unsigned c_SIMM_W       = 10;
    localparam logic [4:0]  c_LAST_BIN_OP  = BINOP_CMP;
    localparam logic [4:0]  c_MEM_RRI_OP   = MEM_LDI_B;
    localparam logic [4:0]  c_LAST_MEM_OP  = MEM_STI_W;

    function automatic logic is_legal(input e_kind kind, input logic [4:0] op);
        case (kind)
            KIND_RRR, KIND_RRI:      return op <= c_LAST_BIN_OP;
            KIND_MEMORY:             return op <= c_LAST_MEM_OP;
            KIND_MODEL, KIND_CUSTOM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rri_format(input e_kind kind, input logic [4:0] op);
        return (kind == KIND_RRI) || ((kind == KIND_MEMORY) && (op >= c_MEM_RRI_OP));
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_queue_if.sv
`default_nettype none
// ============================================================================
// Interface : decode_queue_if
// Brief     : Fetch-side and issue-side handshakes of the decode queue.
// Revision  : 1.0 - initial release
// ============================================================================
interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    import p_decode::*;

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_word;
    logic                   out_valid;
    logic                   out_ready;
    s_dec_hdr               out_hdr;
    logic [XLEN-1:0]        out_imm;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output flush, in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_hdr, out_imm, count
    );

    modport slave (
        input  flush, in_valid, in_word, out_ready,
        output in_ready, out_valid, out_hdr, out_imm, count
    );
endinterface
`default_nettype wire

// File: rtl/decode_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module  : decode_fifo
// Brief   : Registered-storage FIFO of decoded entries; no write-to-read bypass.
// Revision: 1.0 - initial release
// ============================================================================
module decode_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign valid  = (r_count != '0);
    assign full   = (r_count == (AW+1)'(DEPTH));
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    // a pop frees the slot being written, so push-while-full is legal
    assign w_pop  = pop && valid;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module  : decode_queue
// Brief   : Decodes fetch words, gathers long-immediate extension words and
//           queues decoded instructions for issue.
// Revision: 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_queue_if.slave bus
);
    import p_instruction::*;
    import p_decode::*;

    localparam int EXT_WORDS = XLEN / 32;
    localparam int EC_W      = (EXT_WORDS > 1) ? $clog2(EXT_WORDS) : 1;
    localparam int ENTRY_W   = c_HDR_W + XLEN;

    localparam logic [0:0] ST_OPC = 1'b0;
    localparam logic [0:0] ST_EXT = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_next_state;
    logic [EC_W-1:0]        r_ext_cnt;
    s_dec_hdr               r_hdr;
    logic [XLEN-1:0]        r_imm;
    s_dec_hdr               w_dec;
    logic [XLEN-1:0]        w_dec_imm;
    logic [XLEN-1:0]        w_ext_imm;
    logic                   w_legal;
    logic                   w_rri;
    logic                   w_needs_ext;
    logic                   w_ext_last;
    logic                   w_space;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_fifo_valid;
    logic [ENTRY_W-1:0]     w_push_data;
    logic [ENTRY_W-1:0]     w_head;
    logic [$clog2(DEPTH):0] w_count;

    always_comb begin
        w_dec        = '0;
        w_dec.kind   = e_kind'(bus.in_word[c_KIND_LSB +: 3]);
        w_dec.cond   = e_cond'(bus.in_word[c_COND_LSB +: 3]);
        w_dec.op.raw = bus.in_word[c_OP_LSB +: 5];
        w_dec.rd     = bus.in_word[c_RD_LSB +: 5];
        w_dec.rs     = bus.in_word[c_RS_LSB +: 5];
        w_legal      = is_legal(w_dec.kind, w_dec.op.raw);
        w_rri        = uses_rri_format(w_dec.kind, w_dec.op.raw);
        w_dec_imm    = '0;
        if (w_rri) begin
            if (w_legal && !bus.in_word[c_EXT_BIT])
                w_dec_imm = {{(XLEN-c_SIMM_W){bus.in_word[c_SIMM_W-1]}},
                             bus.in_word[c_SIMM_W-1:0]};
        end else begin
            w_dec.rq = bus.in_word[c_RQ_LSB +: 5];
            if (w_dec.kind != KIND_MODEL && w_dec.kind != KIND_CUSTOM) begin
                w_dec.shift_type = bus.in_word[c_SHT_LSB +: 2];
                w_dec.shift_amt  = {1'b0, bus.in_word[c_SHA_LSB +: 4]};
            end
        end
        // illegal words never pull extension words
        w_needs_ext = w_legal && w_rri && bus.in_word[c_EXT_BIT];
        if (!w_legal) begin
            w_dec.kind   = KIND_INVALID;
            w_dec.op.raw = 5'b11111;
        end
    end

    // incoming word lands in slice r_ext_cnt; lower slices were filled earlier
    generate
        for (genvar g = 0; g < EXT_WORDS; g++) begin : g_ext_slice
            assign w_ext_imm[g*32 +: 32] = (r_ext_cnt == EC_W'(g)) ? bus.in_word
                                                                   : r_imm[g*32 +: 32];
        end
    endgenerate

    assign w_ext_last = (r_ext_cnt == EC_W'(EXT_WORDS - 1));
    assign w_pop      = w_fifo_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_OPC;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_OPC:  if (w_accept && w_needs_ext) w_next_state = ST_EXT;
            ST_EXT:  if (w_accept && w_ext_last)  w_next_state = ST_OPC;
            default: w_next_state = ST_OPC;
        endcase
        if (bus.flush) w_next_state = ST_OPC;
    end

    always_comb begin
        w_space     = !w_full || (w_fifo_valid && bus.out_ready);
        w_in_ready  = w_space;
        w_push_data = {w_dec, w_dec_imm};
        if (r_state == ST_EXT) begin
            w_in_ready  = !w_ext_last || w_space;
            w_push_data = {r_hdr, w_ext_imm};
        end
        if (!rst_n || bus.flush) w_in_ready = 1'b0;
        w_accept = bus.in_valid && w_in_ready;
        w_push   = w_accept && ((r_state == ST_EXT) ? w_ext_last : !w_needs_ext);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr     <= '0;
            r_imm     <= '0;
            r_ext_cnt <= '0;
        end else if (bus.flush) begin
            r_hdr     <= '0;
            r_imm     <= '0;
            r_ext_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == ST_OPC) begin
                r_hdr     <= w_dec;
                r_imm     <= '0;
                r_ext_cnt <= '0;
            end else begin
                r_imm     <= w_ext_imm;
                r_ext_cnt <= w_ext_last ? '0 : r_ext_cnt + EC_W'(1);
            end
        end
    end

    decode_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .valid     (w_fifo_valid),
        .full      (w_full),
        .count     (w_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_fifo_valid;
    assign bus.out_hdr   = s_dec_hdr'(w_head[ENTRY_W-1 -: c_HDR_W]);
    assign bus.out_imm   = w_head[XLEN-1:0];
    assign bus.count     = w_count;
endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_queue
// Brief   : Directed self-checking bench for decode_queue at XLEN 32 and 64.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_queue;
    import p_instruction::*;
    import p_decode::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(32), .DEPTH(4)) if32 ();
    decode_queue_if #(.XLEN(64), .DEPTH(4)) if64 ();

    decode_queue #(.XLEN(32), .DEPTH(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    decode_queue #(.XLEN(64), .DEPTH(4)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] w);
        if32.in_valid = 1'b1;
        if32.in_word  = w;
        tick();
        if32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] w);
        if64.in_valid = 1'b1;
        if64.in_word  = w;
        tick();
        if64.in_valid = 1'b0;
    endtask

    task automatic pop32();
        if32.out_ready = 1'b1;
        tick();
        if32.out_ready = 1'b0;
    endtask

    task automatic pop64();
        if64.out_ready = 1'b1;
        tick();
        if64.out_ready = 1'b0;
    endtask

    initial begin
        if32.flush = 1'b0; if32.in_valid = 1'b0; if32.in_word = '0; if32.out_ready = 1'b0;
        if64.flush = 1'b0; if64.in_valid = 1'b0; if64.in_word = '0; if64.out_ready = 1'b0;

        // reset state
        #2;
        chk("rst_in_ready32", if32.in_ready, 1'b0);
        chk("rst_in_ready64", if64.in_ready, 1'b0);
        chk("rst_out_valid",  if32.out_valid, 1'b0);
        chk("rst_count",      if32.count, 0);
        chk("rst_hdr",        if32.out_hdr, 0);
        chk("rst_imm",        if32.out_imm, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", if32.in_ready, 1'b1);

        // plain RRR ADD r1,r2,r3
        send32(32'h000110C0);
        chk("rrr_valid", if32.out_valid, 1'b1);
        chk("rrr_kind",  if32.out_hdr.kind, KIND_RRR);
        chk("rrr_op",    if32.out_hdr.op.raw, 5'd0);
        chk("rrr_rd",    if32.out_hdr.rd, 5'd1);
        chk("rrr_rs",    if32.out_hdr.rs, 5'd2);
        chk("rrr_rq",    if32.out_hdr.rq, 5'd3);
        chk("rrr_sha",   if32.out_hdr.shift_amt, 5'd0);
        chk("rrr_imm",   if32.out_imm, 0);
        pop32();
        chk("rrr_drained", if32.count, 0);

        // RRI with negative short immediate
        if32.in_valid = 1'b1;
        if32.in_word  = 32'h600113FF;
        #1;
        chk("rri_ready_before", if32.in_ready, 1'b1);
        tick();
        if32.in_valid = 1'b0;
        chk("rri_kind",  if32.out_hdr.kind, KIND_RRI);
        chk("rri_imm",   if32.out_imm, 32'hFFFF_FFFF);
        chk("rri_count", if32.count, 1);
        chk("rri_ready_after", if32.in_ready, 1'b1);
        pop32();

        // illegal kind 7 then RRR op 17, back to back
        send32(32'hE000_0000);
        send32(32'h0220_0000);
        chk("ill_count", if32.count, 2);
        chk("ill1_kind", if32.out_hdr.kind, KIND_INVALID);
        chk("ill1_op",   if32.out_hdr.op.raw, 5'b11111);
        chk("ill1_imm",  if32.out_imm, 0);
        pop32();
        chk("ill2_kind", if32.out_hdr.kind, KIND_INVALID);
        chk("ill2_op",   if32.out_hdr.op.raw, 5'b11111);
        pop32();
        chk("ill_drained", if32.out_valid, 1'b0);

        // fill to DEPTH with issue stalled; word k carries rd=k
        for (int k = 1; k <= 5; k++) begin
            if32.in_valid = 1'b1;
            if32.in_word  = 32'(k) << 16;
            #1;
            chk("full_ready", if32.in_ready, (k <= 4) ? 1'b1 : 1'b0);
            if (k <= 4) tick();
        end
        chk("full_count", if32.count, 4);

        // streaming while full: one push and one pop per cycle
        if32.out_ready = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            if32.in_word = 32'(k) << 16;
            #1;
            chk("stream_ready", if32.in_ready, 1'b1);
            tick();
            chk("stream_count", if32.count, 4);
            chk("stream_head",  if32.out_hdr.rd, 5'(k - 3));
        end
        if32.in_valid = 1'b0;
        for (int j = 4; j <= 7; j++) begin
            chk("drain_order", if32.out_hdr.rd, 5'(j));
            tick();
        end
        if32.out_ready = 1'b0;
        chk("drain_count", if32.count, 0);
        chk("drain_valid", if32.out_valid, 1'b0);

        // XLEN=64 extended immediate over two words
        send64(32'h6001_1400);
        chk("ext_hold_count", if64.count, 0);
        if64.in_valid = 1'b1;
        if64.in_word  = 32'hDEAD_BEEF;
        #1;
        chk("ext_mid_ready", if64.in_ready, 1'b1);
        tick();
        if64.in_valid = 1'b0;
        chk("ext_mid_count", if64.count, 0);
        send64(32'h0000_0001);
        chk("ext_count", if64.count, 1);
        chk("ext_kind",  if64.out_hdr.kind, KIND_RRI);
        chk("ext_rd",    if64.out_hdr.rd, 5'd1);
        chk("ext_imm",   if64.out_imm, 64'h0000_0001_DEAD_BEEF);
        pop64();

        // flush mid-EXT with an entry already queued
        send64(32'h000110C0);
        send64(32'h6001_1400);
        send64(32'h1111_1111);
        chk("pre_flush_count", if64.count, 1);
        if64.flush = 1'b1;
        #1;
        chk("flush_ready", if64.in_ready, 1'b0);
        tick();
        if64.flush = 1'b0;
        chk("flush_count", if64.count, 0);
        chk("flush_valid", if64.out_valid, 1'b0);
        send64(32'h000110C0);
        chk("post_flush_count", if64.count, 1);
        chk("post_flush_kind",  if64.out_hdr.kind, KIND_RRR);
        chk("post_flush_rq",    if64.out_hdr.rq, 5'd3);
        chk("post_flush_imm",   if64.out_imm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
